// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and helpers for the button conditioner
// Purpose: repeat-state enum and the counter-width helper used by btn_channel.
// Ports: none (package).
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEATING = 2'd2
  } rep_state_e;

  // Width able to hold max_count itself, one bit of headroom over $clog2.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// rtl/btn_conditioner_if.sv - button conditioner signal bundle
// Purpose: groups raw inputs and conditioned outputs of all channels.
// Ports (members): btn_raw (to conditioner), btn_level, btn_press, btn_release
//   (from conditioner), each NUM_BTN wide.
// Modports: master = button source / consumer, slave = conditioner.
interface btn_conditioner_if #(
  parameter int NUM_BTN = 5
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );

endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchronizer, debounce, edge pulses, auto-repeat
// Purpose: conditions a single raw button level.
// Ports: clk, rst_n (async active-low), raw_i (async raw level),
//   level_o (debounced level), press_o (press / repeat pulse),
//   release_o (release pulse).
// Config: BTN_AUTOREPEAT_EN enables the hold/repeat FSM; otherwise press_o
//   only marks the rising edge of level_o.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            rise, fall;
  logic            tick;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    db_cnt_d = '0;
    level_d  = level_q;
    rise     = 1'b0;
    fall     = 1'b0;
    if (sync2_q != level_q) begin
      // Counter tops out at DB_LAST, where the level flips, so it never wraps.
      if (db_cnt_q >= DB_LAST) begin
        level_d = ~level_q;
        rise    = ~level_q;
        fall    = level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int              REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int              RP_W    = cnt_width(REP_MAX);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

  rep_state_e      state_q, state_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rep_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

  // A release always wins over a due repeat tick on the same edge.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    tick      = 1'b0;
    case (state_q)
      IDLE: begin
        rep_cnt_d = '0;
        if (rise) state_d = HOLD_WAIT;
      end
      HOLD_WAIT: begin
        if (fall) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q >= RD_LAST) begin
          state_d   = REPEATING;
          rep_cnt_d = '0;
          tick      = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
      end
      REPEATING: begin
        if (fall) begin
          state_d   = IDLE;
          rep_cnt_d = '0;
        end else if (rep_cnt_q >= RP_LAST) begin
          rep_cnt_d = '0;
          tick      = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + RP_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        rep_cnt_d = '0;
      end
    endcase
  end
`else
  always_comb begin
    tick = 1'b0;
  end
`endif

  always_comb begin
    press_d   = rise | tick;
    release_d = fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - multi-channel button debouncer with edge and repeat pulses
// Purpose: instantiates one btn_channel per button; wiring only.
// Ports: CLK_100MHz (clock), RST_n (async active-low reset),
//   btn_io (slave modport: btn_raw in; btn_level, btn_press, btn_release out).
// Config: BTN_AUTOREPEAT_EN enables auto-repeat; REPEAT_* are ignored without it.
module btn_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic               CLK_100MHz,
  input  logic               RST_n,
  btn_conditioner_if.slave   btn_io
);

  if (NUM_BTN < 1) begin : g_bad_num_btn
    $error("btn_conditioner: NUM_BTN must be >= 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("btn_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_DELAY < 1) begin : g_bad_rep_delay
    $error("btn_conditioner: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_rep_period
    $error("btn_conditioner: REPEAT_PERIOD must be >= 1");
  end
`endif

  wire [NUM_BTN-1:0] level_w;
  wire [NUM_BTN-1:0] press_w;
  wire [NUM_BTN-1:0] release_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_channel (
      .clk       (CLK_100MHz),
      .rst_n     (RST_n),
      .raw_i     (btn_io.btn_raw[i]),
      .level_o   (level_w[i]),
      .press_o   (press_w[i]),
      .release_o (release_w[i])
    );
  end

  assign btn_io.btn_level   = level_w;
  assign btn_io.btn_press   = press_w;
  assign btn_io.btn_release = release_w;

endmodule
